// File: rtl/mdu_ctrl.sv
// HI/LO multiply-divide sequencer: fixed-latency mult/div with a busy window,
// single-cycle mthi/mtlo, and a pipeline stall request.
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        cancel,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t        state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic [1:0]    op_r, op_s;
  logic [31:0]   a_r, a_s, b_r, b_s;
  logic [31:0]   hi_r, hi_s, lo_r, lo_s;
  logic          busy_r;

  logic [63:0]   ext_a_s, ext_b_s, prod_s;
  logic          neg_a_s, neg_b_s;
  logic [31:0]   mag_a_s, mag_b_s, uq_s, ur_s, quo_s, rem_s;

  // Only the low 64 bits of the product are kept, so one multiplier over
  // sign- or zero-extended operands serves both signed and unsigned forms.
  always_comb begin
    ext_a_s = op_r[0] ? {32'd0, a_r} : {{32{a_r[31]}}, a_r};
    ext_b_s = op_r[0] ? {32'd0, b_r} : {{32{b_r[31]}}, b_r};
    prod_s  = ext_a_s * ext_b_s;
    neg_a_s = ~op_r[0] & a_r[31];
    neg_b_s = ~op_r[0] & b_r[31];
    mag_a_s = neg_a_s ? (32'd0 - a_r) : a_r;
    mag_b_s = neg_b_s ? (32'd0 - b_r) : b_r;
    uq_s    = mag_a_s / mag_b_s;
    ur_s    = mag_a_s % mag_b_s;
    // Sign-magnitude division makes 0x80000000 / -1 wrap to 0x80000000 naturally.
    quo_s   = (neg_a_s ^ neg_b_s) ? (32'd0 - uq_s) : uq_s;
    rem_s   = neg_a_s ? (32'd0 - ur_s) : ur_s;
  end

  // Next-state, operand latch and HI/LO write selection.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    op_s    = op_r;
    a_s     = a_r;
    b_s     = b_r;
    hi_s    = hi_r;
    lo_s    = lo_r;
    case (state_r)
      IDLE: begin
        if (start && !cancel) begin
          case (op)
            3'b000, 3'b001, 3'b010, 3'b011: begin
              state_s = BUSY;
              cnt_s   = op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
              op_s    = op[1:0];
              a_s     = A;
              b_s     = B;
            end
            3'b100:  hi_s = A;
            3'b101:  lo_s = A;
            default: state_s = IDLE;
          endcase
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        cnt_s = cnt_r - CW'(1);
        if (cnt_r == CW'(1)) begin
          state_s = IDLE;
          if (!op_r[1]) begin
            {hi_s, lo_s} = prod_s;
          end else if (b_r != 32'd0) begin
            hi_s = rem_s;
            lo_s = quo_s;
          end else begin
            hi_s = hi_r;
            lo_s = lo_r;
          end
        end else begin
          state_s = BUSY;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State, operand and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      op_r    <= 2'b00;
      a_r     <= 32'd0;
      b_r     <= 32'd0;
      hi_r    <= 32'd0;
      lo_r    <= 32'd0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      op_r    <= op_s;
      a_r     <= a_s;
      b_r     <= b_s;
      hi_r    <= hi_s;
      lo_r    <= lo_s;
      busy_r  <= (state_s == BUSY);
    end
  end

  assign busy      = busy_r;
  assign HI        = hi_r;
  assign LO        = lo_r;
  assign stall_req = busy_r | (start & ~cancel & ~op[2]);

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: stimulus queues expected HI/LO and busy length,
// a negedge monitor checks each completion.
module tb_mdu_ctrl;
  logic        clk, reset, start, cancel;
  logic [2:0]  op;
  logic [31:0] A, B;
  logic        busy, stall_req;
  logic [31:0] HI, LO;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
    .cancel(cancel), .busy(busy), .stall_req(stall_req), .HI(HI), .LO(LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Completion monitor: a busy run ending pops one expectation.
  initial begin : monitor
    int run;
    exp_t e;
    run = 0;
    forever begin
      @(negedge clk);
      if (busy === 1'b1) begin
        run++;
      end else if (run > 0) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_completion: got busy run %0d expected none", run);
        end else begin
          e = exp_q.pop_front();
          chk("busy_len", 32'(run), 32'(e.cyc));
          chk("hi", HI, e.hi);
          chk("lo", LO, e.lo);
        end
        run = 0;
      end
    end
  end

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #2;
    start = 1'b1; op = o; A = a; B = b; cancel = 1'b0;
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (n < 50) begin
      @(negedge clk);
      if (busy === 1'b0) break;
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: got busy after %0d cycles expected idle", n);
    end
  endtask

  initial begin : stim
    reset = 1'b1; start = 1'b0; cancel = 1'b0; op = 3'b000; A = 32'd0; B = 32'd0;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    chk("rst_stall", {31'd0, stall_req}, 32'd0);

    exp_q.push_back('{32'hFFFFFFFF, 32'hFFFFFFFE, 5});
    issue(3'b000, 32'hFFFFFFFF, 32'd2);
    wait_idle();
    exp_q.push_back('{32'h00000001, 32'hFFFFFFFE, 5});
    issue(3'b001, 32'hFFFFFFFF, 32'd2);
    wait_idle();
    exp_q.push_back('{32'hFFFFFFFF, 32'hFFFFFFFD, 10});
    issue(3'b010, 32'hFFFFFFF9, 32'd2);
    wait_idle();
    exp_q.push_back('{32'hFFFFFFFF, 32'hFFFFFFFD, 10});
    issue(3'b011, 32'd1234, 32'd0);
    wait_idle();
    exp_q.push_back('{32'h00000000, 32'h80000000, 10});
    issue(3'b010, 32'h80000000, 32'hFFFFFFFF);
    wait_idle();

    // Cancelled mult: stall only while cancel is low, no effect at the edge.
    @(posedge clk); #2;
    start = 1'b1; op = 3'b000; A = 32'd7; B = 32'd9; cancel = 1'b0;
    #1;
    chk("stall_nocancel", {31'd0, stall_req}, 32'd1);
    cancel = 1'b1;
    #1;
    chk("stall_cancel", {31'd0, stall_req}, 32'd0);
    @(posedge clk); #2;
    start = 1'b0; cancel = 1'b0;
    #1;
    chk("cancel_busy", {31'd0, busy}, 32'd0);
    chk("cancel_hi", HI, 32'h00000000);
    chk("cancel_lo", LO, 32'h80000000);

    // mthi in idle.
    start = 1'b1; op = 3'b100; A = 32'h1234;
    #1;
    chk("mthi_stall", {31'd0, stall_req}, 32'd0);
    @(posedge clk); #2;
    start = 1'b0;
    #1;
    chk("mthi_hi", HI, 32'h00001234);
    chk("mthi_lo", LO, 32'h80000000);
    chk("mthi_busy", {31'd0, busy}, 32'd0);

    // mtlo held during a busy mult must be ignored.
    exp_q.push_back('{32'h00000000, 32'd12, 5});
    issue(3'b000, 32'd3, 32'd4);
    for (int i = 0; i < 3; i++) begin
      start = 1'b1; op = 3'b101; A = 32'hDEAD;
      #1;
      chk("mtlo_busy_stall", {31'd0, stall_req}, 32'd1);
      @(posedge clk); #2;
    end
    start = 1'b0;
    wait_idle();

    // Reset during busy cycle 3 of a div.
    exp_q.push_back('{32'h00000000, 32'h00000000, 3});
    issue(3'b010, 32'd100, 32'd7);
    @(posedge clk);
    @(posedge clk); #2;
    reset = 1'b1;
    @(posedge clk); #2;
    reset = 1'b0;
    repeat (12) @(posedge clk);
    #2;
    chk("post_reset_hi", HI, 32'd0);
    chk("post_reset_lo", LO, 32'd0);

    // Operand changes during busy must not leak into the result.
    exp_q.push_back('{32'h00000000, 32'd15, 5});
    issue(3'b001, 32'd3, 32'd5);
    for (int i = 0; i < 5; i++) begin
      A = $urandom; B = $urandom;
      @(posedge clk); #2;
    end
    wait_idle();

    // Reserved op is ignored.
    @(posedge clk); #2;
    start = 1'b1; op = 3'b110; A = 32'hAAAA; B = 32'hBBBB;
    @(posedge clk); #2;
    start = 1'b0;
    #1;
    chk("rsvd_busy", {31'd0, busy}, 32'd0);
    chk("rsvd_hi", HI, 32'h00000000);
    chk("rsvd_lo", LO, 32'd15);

    repeat (3) @(posedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 The block SHALL have parameter MULT_CYCLES, default 5, giving the busy duration of mult/multu in cycles.
REQ-002 The block SHALL have parameter DIV_CYCLES, default 10, giving the busy duration of div/divu in cycles.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: EX-stage HI/LO instruction valid this cycle.
REQ-006 The block SHALL have port op, input, 3 bits, with this encoding:
- 000 mult
- 001 multu
- 010 div
- 011 divu
- 100 mthi
- 101 mtlo
- 110/111 reserved
REQ-007 The block SHALL have port A, input, 32 bits: rs operand.
REQ-008 The block SHALL have port B, input, 32 bits: rt operand.
REQ-009 The block SHALL have port cancel, input, 1 bit: exception/interrupt flush; a start in the same cycle SHALL have no effect.
REQ-010 The block SHALL have port busy, output, 1 bit: an operation is in progress.
REQ-011 The block SHALL have port stall_req, output, 1 bit: request to hold IF/ID and bubble ID/EX.
REQ-012 The block SHALL have port HI, output, 32 bits: HI register.
REQ-013 The block SHALL have port LO, output, 32 bits: LO register.

Function
REQ-014 The block SHALL implement two states:
- IDLE (busy=0)
- BUSY (busy=1), with an internal down-counter cnt and latched copies of op, A and B.
REQ-015 "Accept" SHALL mean: start=1, cancel=0, state IDLE, op in 000..011. On accept, the block SHALL latch op/A/B, load cnt with MULT_CYCLES (op 00x) or DIV_CYCLES (op 01x), and enter BUSY.
REQ-016 In BUSY, each edge SHALL decrement cnt. On the edge where cnt==1, the block SHALL write HI/LO and return to IDLE, so busy is high for exactly N cycles after the accepting edge.
REQ-017 Results SHALL depend only on the values latched at accept; A/B changes during BUSY SHALL have no effect.
REQ-018 mult SHALL compute the signed 64-bit product and multu the unsigned one, with {HI,LO} = product.
REQ-019 div SHALL perform signed division truncating toward zero: LO=quotient, HI=remainder (sign of dividend). divu SHALL do the same unsigned.
REQ-020 Division by zero (latched B==0) SHALL leave HI and LO unchanged; busy timing SHALL be unaffected.
REQ-021 div of 0x80000000 by 0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-022 mthi/mtlo with start=1, cancel=0 in IDLE SHALL write A to HI/LO at that edge, with no busy cycle.
REQ-023 A start of any op while BUSY SHALL be ignored; upstream is responsible for holding it via stall_req.
REQ-024 Reserved op codes SHALL be ignored.
REQ-025 stall_req SHALL be combinational: busy | (start & ~cancel & (op[2]==0)).
REQ-026 cancel SHALL NOT abort an operation already in BUSY; it masks only same-cycle starts.
REQ-027 HI/LO SHALL hold their value in every cycle not covered by REQ-016 or REQ-022.

Reset
REQ-028 When reset=1 at an edge, the block SHALL set state=IDLE, cnt=0, busy=0, HI=0, LO=0, and clear latched op/A/B to 0.
REQ-029 reset SHALL take priority over start, cancel and an in-flight completion; an operation interrupted by reset SHALL never write HI/LO.
REQ-030 After reset, stall_req SHALL equal start & ~cancel & ~op[2] in the same cycle.

Verification
REQ-031 The bench SHALL cover these directed scenarios:
- mult A=0xFFFFFFFF, B=2 at edge T: busy=1 for T+1..T+5; HI=0xFFFFFFFF, LO=0xFFFFFFFE visible after edge T+5; multu with the same operands gives HI=1, LO=0xFFFFFFFE.
- div A=-7 (0xFFFFFFF9), B=2: busy for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu with B=0 leaves HI/LO at their previous values after 10 busy cycles.
- mult start with cancel=1: busy stays 0, HI/LO unchanged, stall_req=0 in that cycle.
- mthi A=0x1234 in IDLE: HI=0x1234 after one edge, busy never asserts. mtlo issued during BUSY: ignored, stall_req=1 throughout.
- reset asserted at busy cycle 3 of a div: next cycle busy=0, HI=LO=0, and no later write occurs.
- A changed every cycle during a multu (latched A=3, B=5): final LO=15, HI=0.
